// File: rtl/branch_predictor.sv
// Branch predictor: a table of 2-bit saturating counters indexed by PC.
// The lookup in ID is combinational. The update in EX is applied on the
// rising clock edge. Mispredictions are flagged combinationally, and two
// saturating counters keep statistics on resolved branches and misses.
//
// Handshake: there is no backpressure. lookup_valid_i qualifies the lookup
// inputs and predict_o in the same cycle. update_valid_i qualifies the update
// inputs and mispredict_o in the same cycle; that update is committed on the
// rising edge that ends the cycle.
module branch_predictor #(
  parameter int unsigned IDX_W      = 4,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        predict_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic        update_predicted_i,
  output logic        mispredict_o,
  output logic [15:0] branch_cnt_o,
  output logic [15:0] miss_cnt_o
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [1:0]       table_q [ENTRIES];
  logic [1:0]       table_d [ENTRIES];
  logic [15:0]      branch_cnt_q, branch_cnt_d;
  logic [15:0]      miss_cnt_q,   miss_cnt_d;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [1:0]       update_entry;

  // Word-aligned PC bits select the entry. The byte offset and the upper bits
  // are deliberately dropped, so distant PCs alias onto the same counter.
  assign lookup_idx   = lookup_pc_i[IDX_W+1:2];
  assign update_idx   = update_pc_i[IDX_W+1:2];
  assign update_entry = table_q[update_idx];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                            update_pc_i[31:IDX_W+2], update_pc_i[1:0]};

  // The lookup reads the stored value with no bypass, so an update to the
  // same index becomes visible one cycle later. Gating with rst_i holds both
  // flags at 0 during reset, whatever INIT_STATE is.
  assign predict_o    = rst_i & lookup_valid_i & table_q[lookup_idx][1];
  assign mispredict_o = rst_i & update_valid_i & (update_taken_i ^ update_predicted_i);
  assign branch_cnt_o = branch_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

  // Next table state: the addressed counter moves toward the actual outcome.
  // The carried prediction plays no part here.
  always_comb begin
    table_d = table_q;
    if (update_valid_i) begin
      if (update_taken_i) begin
        table_d[update_idx] = (update_entry == 2'b11) ? 2'b11 : update_entry + 2'd1;
      end else begin
        table_d[update_idx] = (update_entry == 2'b00) ? 2'b00 : update_entry - 2'd1;
      end
    end
  end

  // Next statistics state: both counters stop at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (update_valid_i && (branch_cnt_q != 16'hFFFF)) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
    end
    if (mispredict_o && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  // State registers. The asynchronous reset discards history and counts at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= INIT_STATE;
      end
      branch_cnt_q <= 16'd0;
      miss_cnt_q   <= 16'd0;
    end else begin
      table_q      <= table_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule
